// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-ported dmem between the processor (p_*) and debug (d_*) ports.
// Build option DMEM_ARB_RR_EN: round-robin tie-break with a burst limit on both ports; default is fixed processor priority.
module dmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic              p_wren,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,

  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_wren,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_P,
    OWNER_D
  } owner_e;

  // port: 0 = processor, 1 = debug
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  localparam logic PORT_P = 1'b0;
  localparam logic PORT_D = 1'b1;

  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
    $error("dmem_arbiter: RD_LAT must be 1 or 2");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("dmem_arbiter: MAX_BURST must be in 1..15");
  end

  owner_e            owner_q, owner_d;
  logic [3:0]        burst_q, burst_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] p_rdata_q, d_rdata_q;
  tag_t              tag_q [RD_LAT];

  logic              p_win, d_win, any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wren;
  tag_t              tag_in, tag_out;

  // Grant decision: combinational from requests and registered ownership state.
  always_comb begin : arbitrate
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    p_win = 1'b0;
    d_win = 1'b0;
`ifdef DMEM_ARB_RR_EN
    if (p_req && d_req) begin
      unique case (owner_q)
        OWNER_P: begin
          d_win = (burst_q >= 4'(MAX_BURST));
          p_win = !d_win;
        end
        OWNER_D: begin
          p_win = (burst_q >= 4'(MAX_BURST));
          d_win = !p_win;
        end
        default: begin
          p_win = (last_q == PORT_D);
          d_win = !p_win;
        end
      endcase
    end else begin
      p_win = p_req;
      d_win = d_req;
    end
`else
    // Processor wins every tie, so it preempts a debug burst immediately.
    p_win = p_req;
    d_win = d_req && !p_req;
`endif
    if (!reset) begin
      p_win = 1'b0;
      d_win = 1'b0;
    end
  end

  assign p_gnt   = p_win;
  assign d_gnt   = d_win;
  assign any_gnt = p_win || d_win;

  assign sel_addr  = d_win ? d_addr  : p_addr;
  assign sel_wdata = d_win ? d_wdata : p_wdata;
  assign sel_wren  = d_win ? d_wren  : p_wren;

  // Address and data hold their last driven value while nobody is granted.
  assign address_dmem = any_gnt ? sel_addr  : addr_q;
  assign data         = any_gnt ? sel_wdata : wdata_q;
  assign wren         = any_gnt && sel_wren;

  always_comb begin : next_state
    owner_d = OWNER_NONE;
    burst_d = '0;
    last_d  = last_q;
    if (any_gnt) begin
      owner_d = d_win ? OWNER_D : OWNER_P;
      last_d  = d_win;
      if (owner_d != owner_q) begin
        burst_d = 4'd1;
      end else if (burst_q != 4'hF) begin
        burst_d = burst_q + 4'd1;
      end else begin
        burst_d = burst_q;
      end
    end
  end

  always_comb begin : tag_push
    tag_in.valid = any_gnt && !sel_wren;
    tag_in.port  = d_win;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q <= OWNER_NONE;
      burst_q <= '0;
      last_q  <= PORT_D;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (any_gnt) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // NOTE: the tag pipe is reset (unlike a data store) because a stale valid bit would fire a bogus rvalid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out  = tag_q[RD_LAT-1];
  assign p_rvalid = tag_out.valid && (tag_out.port == PORT_P);
  assign d_rvalid = tag_out.valid && (tag_out.port == PORT_D);

  // Returned data passes straight through in the rvalid cycle, then is held.
  assign p_rdata = p_rvalid ? q_dmem : p_rdata_q;
  assign d_rdata = d_rvalid ? q_dmem : d_rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (p_rvalid) p_rdata_q <= q_dmem;
      if (d_rvalid) d_rdata_q <= q_dmem;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance A (RD_LAT=1, MAX_BURST=4) and instance B (RD_LAT=2, MAX_BURST=1).
// Expected read returns go into per-port scoreboard queues and are popped when rvalid appears.
module tb_dmem_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  // 0: A processor, 1: A debug, 2: B processor, 3: B debug
  exp_t sbq [4][$];

  logic        pa_req, pa_wren, pa_gnt, pa_rvalid;
  logic [11:0] pa_addr;
  logic [31:0] pa_wdata, pa_rdata;
  logic        da_req, da_wren, da_gnt, da_rvalid;
  logic [11:0] da_addr;
  logic [31:0] da_wdata, da_rdata;
  logic [11:0] addr_a;
  logic [31:0] data_a, q_a;
  logic        wren_a;

  logic        pb_req, pb_wren, pb_gnt, pb_rvalid;
  logic [11:0] pb_addr;
  logic [31:0] pb_wdata, pb_rdata;
  logic        db_req, db_wren, db_gnt, db_rvalid;
  logic [11:0] db_addr;
  logic [31:0] db_wdata, db_rdata;
  logic [11:0] addr_b;
  logic [31:0] data_b, q_b;
  logic        wren_b;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1), .MAX_BURST(4)) u_dut_a (
    .clock(clock), .reset(reset),
    .p_req(pa_req), .p_addr(pa_addr), .p_wdata(pa_wdata), .p_wren(pa_wren),
    .p_gnt(pa_gnt), .p_rvalid(pa_rvalid), .p_rdata(pa_rdata),
    .d_req(da_req), .d_addr(da_addr), .d_wdata(da_wdata), .d_wren(da_wren),
    .d_gnt(da_gnt), .d_rvalid(da_rvalid), .d_rdata(da_rdata),
    .address_dmem(addr_a), .data(data_a), .wren(wren_a), .q_dmem(q_a)
  );

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(2), .MAX_BURST(1)) u_dut_b (
    .clock(clock), .reset(reset),
    .p_req(pb_req), .p_addr(pb_addr), .p_wdata(pb_wdata), .p_wren(pb_wren),
    .p_gnt(pb_gnt), .p_rvalid(pb_rvalid), .p_rdata(pb_rdata),
    .d_req(db_req), .d_addr(db_addr), .d_wdata(db_wdata), .d_wren(db_wren),
    .d_gnt(db_gnt), .d_rvalid(db_rvalid), .d_rdata(db_rdata),
    .address_dmem(addr_b), .data(data_b), .wren(wren_b), .q_dmem(q_b)
  );

  // dmem contents as a fixed function of address; word 0x010 reads 0xDEADBEEF.
  function automatic logic [31:0] rom(input logic [11:0] a);
    return 32'hDEAD_BEEF ^ ({20'h0, a} * 32'h0001_0001) ^ 32'h0010_0010;
  endfunction

  logic [31:0] qa_q, qb_q1, qb_q2;
  always @(posedge clock) begin
    qa_q  <= rom(addr_a);
    qb_q1 <= rom(addr_b);
    qb_q2 <= qb_q1;
  end
  assign q_a = qa_q;
  assign q_b = qb_q2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [11:0] a, input int lat);
    exp_t e;
    e.cyc  = cyc + lat;
    e.data = rom(a);
    sbq[k].push_back(e);
  endtask

  task automatic mon(input int k, input logic rv, input logic [31:0] rd);
    exp_t e;
    if (rv) begin
      if (sbq[k].size() == 0) begin
        check($sformatf("rv%0d_unexpected", k), {31'b0, rv}, 32'd0);
      end else begin
        e = sbq[k].pop_front();
        check($sformatf("rv%0d_cycle", k), cyc, e.cyc);
        check($sformatf("rv%0d_data", k), rd, e.data);
      end
    end
  endtask

  always @(negedge clock) begin
    mon(0, pa_rvalid, pa_rdata);
    mon(1, da_rvalid, da_rdata);
    mon(2, pb_rvalid, pb_rdata);
    mon(3, db_rvalid, db_rdata);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  bit exp_a_d [10];
  bit exp_b_d [6];

  initial begin
`ifdef DMEM_ARB_RR_EN
    exp_a_d = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    exp_b_d = '{0, 1, 0, 1, 0, 1};
`else
    exp_a_d = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_b_d = '{0, 0, 0, 0, 0, 0};
`endif
    pa_req = 0; pa_addr = '0; pa_wdata = '0; pa_wren = 0;
    da_req = 0; da_addr = '0; da_wdata = '0; da_wren = 0;
    pb_req = 0; pb_addr = '0; pb_wdata = 32'hA5A5_A5A5; pb_wren = 0;
    db_req = 0; db_addr = '0; db_wdata = 32'h5A5A_5A5A; db_wren = 0;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Requests during reset must not be granted.
    step();
    pa_req = 1; pa_addr = 12'h010;
    da_req = 1; da_wren = 1; da_addr = 12'h0FF; da_wdata = 32'h1234_5678;
    pb_req = 1; db_req = 1;
    sample();
    check("rst_p_gnt", pa_gnt, 0);
    check("rst_d_gnt", da_gnt, 0);
    check("rst_wren", wren_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_data", data_a, 0);
    check("rst_p_rdata", pa_rdata, 0);
    check("rst_d_rdata", da_rdata, 0);
    check("rst_p_rvalid", pa_rvalid, 0);
    check("rst_d_rvalid", da_rvalid, 0);
    check("rst_b_gnt", {pb_gnt, db_gnt}, 0);

    // Release reset; processor read is granted in the very first cycle.
    #1 reset = 1'b1;
    da_req = 0; pb_req = 0; db_req = 0;
    #1;
    check("a_rd_p_gnt", pa_gnt, 1);
    check("a_rd_d_gnt", da_gnt, 0);
    check("a_rd_addr", addr_a, 12'h010);
    check("a_rd_wren", wren_a, 0);
    push(0, 12'h010, 1);

    // Debug write in the cycle the processor read returns.
    step();
    pa_req = 0;
    da_req = 1;
    sample();
    check("a_wr_d_gnt", da_gnt, 1);
    check("a_wr_p_gnt", pa_gnt, 0);
    check("a_wr_wren", wren_a, 1);
    check("a_wr_addr", addr_a, 12'h0FF);
    check("a_wr_data", data_a, 32'h1234_5678);

    step();
    da_req = 0;
    sample();
    check("a_idle_wren", wren_a, 0);
    check("a_idle_addr_hold", addr_a, 12'h0FF);
    check("a_idle_data_hold", data_a, 32'h1234_5678);
    check("a_p_rdata_hold", pa_rdata, 32'hDEAD_BEEF);

    // Both ports reading continuously.
    step();
    pa_req = 1; pa_wren = 0; pa_addr = 12'h100;
    da_req = 1; da_wren = 0; da_addr = 12'h200;
    for (int i = 0; i < 10; i++) begin
      sample();
      check($sformatf("a_tie%0d_p_gnt", i), pa_gnt, {31'b0, !exp_a_d[i]});
      check($sformatf("a_tie%0d_d_gnt", i), da_gnt, {31'b0, exp_a_d[i]});
      check($sformatf("a_tie%0d_addr", i), addr_a, exp_a_d[i] ? da_addr : pa_addr);
      push(exp_a_d[i] ? 1 : 0, exp_a_d[i] ? da_addr : pa_addr, 1);
      step();
      if (exp_a_d[i]) da_addr = da_addr + 12'd1;
      else pa_addr = pa_addr + 12'd1;
    end
    pa_req = 0;
    sample();
    check("a_pdrop_d_gnt", da_gnt, 1);
    check("a_pdrop_p_gnt", pa_gnt, 0);
    push(1, da_addr, 1);
    step();
    da_req = 0;
    repeat (3) step();

    // Instance B: RD_LAT=2, reads on consecutive cycles from different ports.
    pb_req = 1; pb_addr = 12'h020;
    sample();
    check("b_rd0_p_gnt", pb_gnt, 1);
    check("b_rd0_addr", addr_b, 12'h020);
    push(2, 12'h020, 2);
    step();
    pb_req = 0;
    db_req = 1; db_addr = 12'h030;
    sample();
    check("b_rd1_d_gnt", db_gnt, 1);
    check("b_rd1_p_gnt", pb_gnt, 0);
    push(3, 12'h030, 2);
    step();
    db_req = 0;
    repeat (3) step();

    // MAX_BURST=1 contention.
    pb_req = 1; pb_addr = 12'h100;
    db_req = 1; db_addr = 12'h200;
    for (int i = 0; i < 6; i++) begin
      sample();
      check($sformatf("b_tie%0d_p_gnt", i), pb_gnt, {31'b0, !exp_b_d[i]});
      check($sformatf("b_tie%0d_d_gnt", i), db_gnt, {31'b0, exp_b_d[i]});
      push(exp_b_d[i] ? 3 : 2, exp_b_d[i] ? db_addr : pb_addr, 2);
      step();
      if (exp_b_d[i]) db_addr = db_addr + 12'd1;
      else pb_addr = pb_addr + 12'd1;
    end
    pb_req = 0; db_req = 0;
    repeat (3) step();

    // Reset while a read is in flight: the read must vanish.
    pb_req = 1; pb_addr = 12'h040;
    sample();
    check("b_mid_p_gnt", pb_gnt, 1);
    step();
    pb_req = 0;
    #1 reset = 1'b0;
    #1;
    check("b_mrst_p_gnt", pb_gnt, 0);
    check("b_mrst_d_gnt", db_gnt, 0);
    check("b_mrst_wren", wren_b, 0);
    check("b_mrst_addr", addr_b, 0);
    check("b_mrst_data", data_b, 0);
    check("b_mrst_p_rdata", pb_rdata, 0);
    check("b_mrst_d_rdata", db_rdata, 0);
    check("b_mrst_p_rvalid", pb_rvalid, 0);
    check("b_mrst_d_rvalid", db_rvalid, 0);
    step();
    step();
    reset = 1'b1;
    repeat (4) step();

    pb_req = 1; pb_addr = 12'h050;
    sample();
    check("b_post_p_gnt", pb_gnt, 1);
    push(2, 12'h050, 2);
    step();
    pb_req = 0;
    repeat (4) step();

    for (int k = 0; k < 4; k++) begin
      check($sformatf("sb%0d_drained", k), sbq[k].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
